// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths and defaults for the instruction-fetch front end.
// Consumed by inst_fetch_queue and fetch_fifo (FETCHQ_BYPASS_EN is handled in the top).
package inst_fetch_queue_pkg;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int INST_BUS_W = 32;
  localparam logic [INST_ADDR_BUS_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int DEFAULT_PC_STEP = 4;
  localparam logic [INST_BUS_W-1:0] NOP_INST = '0;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through queue of {pc, inst} entries with synchronous flush.
// Flush wins over push and pop; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [W-1:0]     push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [LVL_W-1:0] level_o,
  output logic             head_valid_o,
  output logic [W-1:0]     head_data_o
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push_i & ~flush_i;
    do_pop   = pop_i & ~flush_i & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign level_o      = count_q;
  assign head_valid_o = (count_q != '0);
  assign head_data_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch PC, ROM request issue and redirect/flush control in front of fetch_fifo.
// Define FETCHQ_BYPASS_EN to forward returning data straight to decode when the queue is empty.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS_W,
  parameter int                INST_W   = INST_BUS_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                PC_STEP  = DEFAULT_PC_STEP,
  localparam int               LVL_W    = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [LVL_W-1:0]  level_o
);
  localparam int ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] ret_pc_q, ret_pc_d;
  logic              inflight_q, inflight_d;

  logic              issue, ret_ok, bypass_hit, push, pop;
  logic [ADDR_W-1:0] issue_addr;
  logic [LVL_W-1:0]  fifo_level;
  logic              head_valid;
  logic [ENT_W-1:0]  head_data;

  // Credit counts the in-flight return; a pop in the same cycle frees nothing yet.
  always_comb begin
    issue      = rst & (redirect_i | ((int'(fifo_level) + int'(inflight_q)) < DEPTH));
    issue_addr = redirect_i ? redirect_addr_i : fetch_pc_q;
    ret_ok     = inflight_q & ~redirect_i;
`ifdef FETCHQ_BYPASS_EN
    bypass_hit = ret_ok & ~head_valid;
`else
    bypass_hit = 1'b0;
`endif
    push       = ret_ok & ~(bypass_hit & ~stall_i);
    pop        = head_valid & ~stall_i & ~redirect_i;
    fetch_pc_d = issue ? issue_addr + ADDR_W'(PC_STEP) : fetch_pc_q;
    ret_pc_d   = issue ? issue_addr : ret_pc_q;
    inflight_d = issue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      ret_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ret_pc_q   <= ret_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst),
    .push_i       (push),
    .push_data_i  ({ret_pc_q, rom_data_i}),
    .pop_i        (pop),
    .flush_i      (redirect_i),
    .level_o      (fifo_level),
    .head_valid_o (head_valid),
    .head_data_o  (head_data)
  );

  always_comb begin
    rom_ce_o   = issue;
    rom_addr_o = rst ? issue_addr : '0;
    level_o    = fifo_level;
    id_valid_o = head_valid | bypass_hit;
    id_pc_o    = '0;
    id_inst_o  = NOP_INST[INST_W-1:0];
    if (head_valid) begin
      id_pc_o   = head_data[ENT_W-1:INST_W];
      id_inst_o = head_data[INST_W-1:0];
    end else if (bypass_hit) begin
      id_pc_o   = ret_pc_q;
      id_inst_o = rom_data_i;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue against a queue-level reference model.
// The ROM model returns addr>>2; FETCHQ_BYPASS_EN selects the bypass expectations.
module tb_inst_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        stall_i, redirect_i;
  logic [31:0] redirect_addr_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o, id_inst_o;
  logic [2:0]  level_o;

  int n_checks = 0;
  int n_fail = 0;

  inst_fetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce_o),
    .rom_addr_o      (rom_addr_o),
    .rom_data_i      (rom_data_i),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .id_valid_o      (id_valid_o),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o),
    .level_o         (level_o)
  );

  // ---------------- clock / ROM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk)
    rom_data_i <= rom_ce_o ? (rom_addr_o >> 2) : 32'hDEAD_BEEF;

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] m_fetch_pc, m_ret_pc;
  bit          m_inflight;
  logic        e_ce, e_valid, e_bypass;
  logic [31:0] e_addr, e_pc, e_inst;
  logic [2:0]  e_level;
  logic [31:0] consumed[$];

  function automatic void model_reset();
    exp_q.delete();
    m_fetch_pc = RESET_PC;
    m_ret_pc   = '0;
    m_inflight = 1'b0;
  endfunction

  function automatic void model_eval();
    e_ce     = redirect_i || ((exp_q.size() + int'(m_inflight)) < DEPTH);
    e_addr   = redirect_i ? redirect_addr_i : m_fetch_pc;
    e_level  = 3'(exp_q.size());
    e_bypass = 1'b0;
    e_valid  = 1'b0;
    e_pc     = '0;
    if (exp_q.size() > 0) begin
      e_valid = 1'b1;
      e_pc    = exp_q[0];
    end else if (BYP && m_inflight && !redirect_i) begin
      e_valid  = 1'b1;
      e_pc     = m_ret_pc;
      e_bypass = 1'b1;
    end
    e_inst = e_valid ? (e_pc >> 2) : 32'h0;
  endfunction

  function automatic void model_commit();
    if (redirect_i) begin
      exp_q.delete();
    end else begin
      if (e_valid && !stall_i && !e_bypass) void'(exp_q.pop_front());
      if (m_inflight && !(e_bypass && !stall_i)) exp_q.push_back(m_ret_pc);
    end
    if (e_ce) begin
      m_ret_pc   = e_addr;
      m_fetch_pc = e_addr + PC_STEP;
    end
    m_inflight = e_ce;
  endfunction

  function automatic logic [100:0] act_vec();
    return {rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, level_o};
  endfunction

  function automatic logic [100:0] exp_vec();
    return {e_ce, e_addr, e_valid, e_pc, e_inst, e_level};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_addr_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_commit();
    if (id_valid_o && !stall_i && !redirect_i) consumed.push_back(id_pc_o);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b1;
    redirect_addr_i = 32'h40;
    @(negedge clk);
    n_checks++;
    if (act_vec() !== 101'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 0", act_vec());
    end
    redirect_i = 1'b0;
  endtask

  task automatic test_sequential();
    int first_v = -1;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      model_eval();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL seq cyc%0d got %h required %h", i, act_vec(), exp_vec());
      end
      if (i < 3) begin
        n_checks++;
        if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'(i * 4)}) begin
          n_fail++;
          $display("FAIL seq_issue cyc%0d got ce=%0b addr=%h required ce=1 addr=%h",
                   i, rom_ce_o, rom_addr_o, 32'(i * 4));
        end
      end
      if (id_valid_o && first_v < 0) begin
        first_v = i;
        n_checks++;
        if ({id_pc_o, id_inst_o} !== 64'h0) begin
          n_fail++;
          $display("FAIL seq_first_head got pc=%h inst=%h required 0/0", id_pc_o, id_inst_o);
        end
      end
      clock_edge();
    end
    n_checks++;
    if (first_v != (BYP ? 1 : 2)) begin
      n_fail++;
      $display("FAIL seq_latency got %0d required %0d", first_v, BYP ? 1 : 2);
    end
  endtask

  task automatic test_stall_fill();
    int issues = 0;
    logic [31:0] resume_addr = '1;
    apply_reset();
    stall_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      model_eval();
      if (rom_ce_o) issues++;
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fill cyc%0d got %h required %h", i, act_vec(), exp_vec());
      end
      clock_edge();
    end
    n_checks++;
    if (issues != DEPTH || level_o !== 3'(DEPTH)) begin
      n_fail++;
      $display("FAIL fill_count got issues=%0d level=%0d required %0d/%0d",
               issues, level_o, DEPTH, DEPTH);
    end
    consumed.delete();
    stall_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      model_eval();
      if (rom_ce_o && resume_addr === '1) resume_addr = rom_addr_o;
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL drain cyc%0d got %h required %h", i, act_vec(), exp_vec());
      end
      clock_edge();
    end
    n_checks++;
    if (resume_addr !== 32'h10 || consumed.size() < 4 || consumed[0] !== 32'h0 ||
        consumed[1] !== 32'h4 || consumed[2] !== 32'h8 || consumed[3] !== 32'hC) begin
      n_fail++;
      $display("FAIL drain_order got resume=%h n=%0d required resume=10 order 0,4,8,C",
               resume_addr, consumed.size());
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    stall_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      model_eval();
      clock_edge();
    end
    n_checks++;
    if (level_o !== 3'd3) begin
      n_fail++;
      $display("FAIL redir_pre_level got %0d required 3", level_o);
    end
    consumed.delete();
    redirect_i = 1'b1;
    redirect_addr_i = 32'h100;
    stall_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      model_eval();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL redir cyc%0d got %h required %h", i, act_vec(), exp_vec());
      end
      if (i == 0) begin
        n_checks++;
        if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'h100}) begin
          n_fail++;
          $display("FAIL redir_issue got ce=%0b addr=%h required 1/100", rom_ce_o, rom_addr_o);
        end
      end
      if (i == 1) begin
        n_checks++;
        if (level_o !== 3'd0 || id_valid_o !== BYP) begin
          n_fail++;
          $display("FAIL redir_empty got level=%0d valid=%0b required 0/%0b",
                   level_o, id_valid_o, BYP);
        end
      end
      clock_edge();
      redirect_i = 1'b0;
    end
    n_checks++;
    if (consumed.size() < 2 || consumed[0] !== 32'h100 || consumed[1] !== 32'h104) begin
      n_fail++;
      $display("FAIL redir_order got n=%0d first=%h required 100,104",
               consumed.size(), consumed.size() > 0 ? consumed[0] : 32'hX);
    end
  endtask

  task automatic test_redirect_stall();
    int hits = 0;
    apply_reset();
    repeat (3) begin
      @(negedge clk);
      model_eval();
      clock_edge();
    end
    consumed.delete();
    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_addr_i = 32'h200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      model_eval();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL rstall cyc%0d got %h required %h", i, act_vec(), exp_vec());
      end
      clock_edge();
      redirect_i = 1'b0;
      stall_i = (i < 3);
    end
    foreach (consumed[k]) if (consumed[k] === 32'h200) hits++;
    n_checks++;
    if (consumed.size() == 0 || consumed[0] !== 32'h200 || hits != 1) begin
      n_fail++;
      $display("FAIL rstall_target got n=%0d hits=%0d required first=200 once",
               consumed.size(), hits);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      stall_i = (i >= 3);
      @(negedge clk);
      model_eval();
      clock_edge();
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (act_vec() !== 101'h0) begin
      n_fail++;
      $display("FAIL async_reset got %h required 0", act_vec());
    end
    stall_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      model_eval();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL post_reset cyc%0d got %h required %h", i, act_vec(), exp_vec());
      end
      if (i == 0) begin
        n_checks++;
        if ({rom_ce_o, rom_addr_o, id_valid_o} !== {1'b1, RESET_PC, 1'b0}) begin
          n_fail++;
          $display("FAIL post_reset_issue got ce=%0b addr=%h valid=%0b required 1/%h/0",
                   rom_ce_o, rom_addr_o, id_valid_o, RESET_PC);
        end
      end
      clock_edge();
    end
  endtask

  task automatic test_random_stream();
    int cyc = 0;
    apply_reset();
    consumed.delete();
    while (consumed.size() < 24 && cyc < 400) begin
      stall_i = ($urandom_range(0, 99) < 40);
      @(negedge clk);
      model_eval();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream cyc%0d got %h required %h", cyc, act_vec(), exp_vec());
      end
      clock_edge();
      cyc++;
    end
    n_checks++;
    if (consumed.size() < 24) begin
      n_fail++;
      $display("FAIL stream_timeout got %0d fetches required 24", consumed.size());
    end
    for (int k = 0; k < 20 && k < consumed.size(); k++) begin
      n_checks++;
      if (consumed[k] !== 32'(k * PC_STEP)) begin
        n_fail++;
        $display("FAIL stream_pc idx%0d got %h required %h", k, consumed[k], 32'(k * PC_STEP));
      end
    end
    stall_i = 1'b0;
  endtask

  // ---------------- sequence / final report ----------------
  initial begin
    rst = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_addr_i = '0;
    test_reset();
    test_sequential();
    test_stall_fill();
    test_redirect();
    test_redirect_stall();
    test_async_reset();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
